// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and constants for the MIDI message parser
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    BEND     = 3'd6
  } msg_type_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAIT_D1 = 2'd1;
  localparam state_t ST_WAIT_D2 = 2'd2;
  localparam state_t ST_SYSEX   = 2'd3;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_BASE     = 8'hF8;

  typedef struct packed {
    msg_type_t   msg_type;
    logic [3:0]  chan;
    logic [6:0]  d1;
    logic [6:0]  d2;
  } msg_t;

  // Status nibbles 8..E map onto msg_type_t in order, so bits [6:4] are the type.
  function automatic msg_type_t status_type(input logic [2:0] kind);
    return msg_type_t'(kind);
  endfunction

  function automatic logic has_two_data(input logic [2:0] kind);
    return (kind != 3'd4) && (kind != 3'd5);
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// rtl/midi_msg_parser_if.sv - byte input, channel filter and message output bundle
interface midi_msg_parser_if;
  import midi_pkg::*;

  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_omni;
  logic [3:0]  i_channel;
  logic        o_msg_valid;
  logic        i_msg_ready;
  msg_type_t   o_msg_type;
  logic [3:0]  o_msg_chan;
  logic [6:0]  o_msg_d1;
  logic [6:0]  o_msg_d2;
  logic        o_rt_valid;
  logic [2:0]  o_rt_code;
  logic        o_overflow;

  modport master (
    output i_byte_valid, i_byte, i_omni, i_channel, i_msg_ready,
    input  o_msg_valid, o_msg_type, o_msg_chan, o_msg_d1, o_msg_d2,
           o_rt_valid, o_rt_code, o_overflow
  );

  modport slave (
    input  i_byte_valid, i_byte, i_omni, i_channel, i_msg_ready,
    output o_msg_valid, o_msg_type, o_msg_chan, o_msg_d1, o_msg_d2,
           o_rt_valid, o_rt_code, o_overflow
  );

endinterface

// File: rtl/midi_msg_fifo.sv
// rtl/midi_msg_fifo.sv - synchronous show-ahead FIFO of decoded messages
module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  msg_t push_data,
  input  logic pop,
  output msg_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  msg_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte stream to channel-voice message sequencer
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  midi_msg_parser_if.slave  bus
);

  state_t      state;
  logic [2:0]  st_kind;
  logic [3:0]  st_chan;
  logic [6:0]  d1_q;

  logic        is_data;
  logic        is_rt;
  logic        two_data;
  logic        complete;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        drop;
  msg_t        new_msg;
  msg_t        head;

  assign is_data  = ~bus.i_byte[7];
  assign is_rt    = (bus.i_byte >= RT_BASE);
  assign two_data = has_two_data(st_kind);
  assign complete = bus.i_byte_valid & is_data &
                    (((state == ST_WAIT_D1) & ~two_data) | (state == ST_WAIT_D2));
  assign accept   = bus.i_omni | (st_chan == bus.i_channel);
  assign push     = complete & accept;
  assign pop      = bus.o_msg_valid & bus.i_msg_ready;
  assign drop     = push & full & ~pop;

  always_comb begin
    new_msg.chan     = st_chan;
    new_msg.msg_type = status_type(st_kind);
    if (two_data) begin
      new_msg.d1 = d1_q;
      new_msg.d2 = bus.i_byte[6:0];
    end else begin
      new_msg.d1 = bus.i_byte[6:0];
      new_msg.d2 = 7'd0;
    end
    // Zero-velocity note-on is the common running-status way to release a note.
    if (new_msg.msg_type == NOTE_ON && new_msg.d2 == 7'd0) new_msg.msg_type = NOTE_OFF;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      st_kind        <= 3'd0;
      st_chan        <= 4'd0;
      d1_q           <= 7'd0;
      bus.o_rt_valid <= 1'b0;
      bus.o_rt_code  <= 3'd0;
      bus.o_overflow <= 1'b0;
    end else begin
      bus.o_rt_valid <= 1'b0;
      bus.o_overflow <= bus.o_overflow | drop;
      if (bus.i_byte_valid) begin
        if (is_rt) begin
          bus.o_rt_valid <= 1'b1;
          bus.o_rt_code  <= bus.i_byte[2:0];
        end else if (!is_data) begin
          if (bus.i_byte < SYSEX_START) begin
            st_kind <= bus.i_byte[6:4];
            st_chan <= bus.i_byte[3:0];
            state   <= ST_WAIT_D1;
          end else begin
            // F0 enters sysex; F1-F7 (including SYSEX_END) fall back to idle.
            st_kind <= 3'd0;
            st_chan <= 4'd0;
            state   <= (bus.i_byte == SYSEX_START) ? ST_SYSEX : ST_IDLE;
          end
        end else begin
          case (state)
            ST_WAIT_D1: begin
              if (two_data) begin
                d1_q  <= bus.i_byte[6:0];
                state <= ST_WAIT_D2;
              end
            end
            ST_WAIT_D2: state <= ST_WAIT_D1;
            default:    state <= state;
          endcase
        end
      end
    end
  end

  midi_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (new_msg),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.o_msg_valid = ~empty;
  assign bus.o_msg_type  = empty ? NOTE_OFF : head.msg_type;
  assign bus.o_msg_chan  = empty ? 4'd0 : head.chan;
  assign bus.o_msg_d1    = empty ? 7'd0 : head.d1;
  assign bus.o_msg_d2    = empty ? 7'd0 : head.d2;

endmodule
